// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_add_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

   localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the arithmetic core of the serial adder.
module full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first,
// through a single full_adder with the carry registered between bits.
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter  int WIDTH = SA_DEFAULT_WIDTH,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output sa_state_t        state_dbg
);

   // Handshake: start is only sampled while busy is low; a request seen
   // while busy is dropped. done pulses for one cycle when sum/cout update.
   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, acc;
   logic [CW-1:0]    count;
   logic             carry;
   logic             fa_sum, fa_cout;
   logic             last_bit;

   full_adder u_fa (fa_sum, fa_cout, a_sr[0], b_sr[0], carry);

   assign last_bit  = (count == CW'(WIDTH-1));
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign state_dbg = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sr  <= '0;
         b_sr  <= '0;
         acc   <= '0;
         count <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  count <= '0;
                  acc   <= '0;
               end
            end
            RUN: begin
               // New sum bit enters at the MSB so the LSB lands at bit 0 last.
               acc   <= {fa_sum, acc[WIDTH-1:1]};
               carry <= fa_cout;
               a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
               count <= count + CW'(1);
               if (last_bit) begin
                  sum  <= {fa_sum, acc[WIDTH-1:1]};
                  cout <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an a+b+cin reference.
module tb_serial_adder_ctrl;
   import serial_add_pkg::*;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a, b;
   logic          cin;
   logic          busy, done, cout;
   logic [W-1:0]  sum;
   sa_state_t     state_dbg;

   logic [W:0]    exp_q[$];
   logic [W:0]    last_res;
   int            n_checks = 0;
   int            n_errors = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected result straight from arithmetic: {cout,sum} = a + b + cin.
   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c);
      return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   // Called at #1 after an edge with the DUT idle; the next edge accepts.
   // Cycle c is observed #1 after edge c (edge 0 = acceptance).
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input bit hold, input bit poke);
      logic [W:0] e;
      a = oa; b = ob; cin = oc; start = 1'b1;
      for (int c = 0; c <= W + 1; c++) begin
         @(posedge clk); #1;
         if (c == 0) exp_q.push_back(ref_add(oa, ob, oc));
         if (!hold) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom_range(0, 1));
         end
         if (poke && (c == 3 || c == W)) begin
            start = 1'b1; a = '1; b = '1;
         end
         check("busy", 32'(busy), 32'(c <= W));
         check("done", 32'(done), 32'(c == W));
         if (c == W) begin
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e[W-1:0]));
            check("cout", 32'(cout), 32'(e[W]));
            last_res = e;
         end else begin
            check("hold_sum", 32'(sum), 32'(last_res[W-1:0]));
            check("hold_cout", 32'(cout), 32'(last_res[W]));
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      last_res = '0;
      @(posedge clk); #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      reset = 1'b0;

      repeat (3) begin
         @(posedge clk); #1;
         check("idle_busy", 32'(busy), 32'd0);
      end

      run_op(8'h3C, 8'h42, 1'b0, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
      run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of an operation.
      a = 8'h3C; b = 8'h42; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_sum", 32'(sum), 32'd0);
      check("arst_cout", 32'(cout), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      last_res = '0;
      repeat (W + 2) begin
         @(posedge clk); #1;
         check("post_rst_done", 32'(done), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
      end
      run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

      // start held high: back-to-back operations.
      repeat (3) run_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
      start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         check("after_hold_busy", 32'(busy), 32'd0);
      end

      for (int i = 0; i < 20; i++)
         run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                1'b0, bit'($urandom_range(0, 1)));

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
